decode_pipe: RTL and testbench
==============================

DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 Parameter IMM_W, default 32, width of the extended immediate output; legal range 16..64.
REQ-002 Parameter PC_W, default 32, width of the program-counter tag carried with each instruction.
REQ-003 Parameter DEPTH, default 2, number of decoded-instruction buffer entries; legal range 2..16.
REQ-004 clk_i  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst_n_i  input  1  reset, synchronous, active-low.
REQ-006 flush_i  input  1  discard all buffered entries and the current input.
REQ-007 in_valid_i  input  1  instruction offered.
REQ-008 in_ready_o  output  1  block accepts the offered instruction.
REQ-009 instr_i  input  32  raw MIPS instruction word.
REQ-010 pc_i  input  PC_W  PC tag of instr_i.
REQ-011 sign_ext_i  input  1  extension mode for instr_i: 1 = sign-extend, 0 = zero-extend.
REQ-012 out_valid_o  output  1  head entry valid.
REQ-013 out_ready_i  input  1  consumer takes the head entry.
REQ-014 Head-entry output fields, each an output of the stated width:
- rs_o, rt_o, rd_o, shamt_o: 5
- op_o, funct_o: 6
- target_o: 26
- imm_o: IMM_W
- pc_o: PC_W
- is_r_type_o, is_i_type_o, is_j_type_o, use_link_reg_o: 1

Function
REQ-015 An input transfer occurs when in_valid_i && in_ready_o && !flush_i; an output transfer occurs when out_valid_o && out_ready_i && !flush_i.
REQ-016 Decode is performed at enqueue, and the fully decoded entry is stored in the buffer; outputs are driven from the buffer head register only (no combinational path from instr_i).
REQ-017 Field extraction:
- rs = instr[25:21], rt = instr[20:16], rd = instr[15:11]
- shamt = instr[10:6], op = instr[31:26], funct = instr[5:0]
- target = instr[25:0]
REQ-018 imm = instr[15:0] extended to IMM_W: bit 15 replicated if sign_ext_i = 1, zeros otherwise; sign_ext_i is sampled in the same cycle as instr_i.
REQ-019 Type flags:
- is_r = (op == 0x00)
- is_j = (op == 0x02 || op == 0x03)
- is_i = !is_r && !is_j
- Exactly one flag is set per entry.
REQ-020 use_link_reg is set in any of these cases, and is 0 otherwise:
- op == 0x01 with rt == 0x10 or rt == 0x11 (BLTZAL, BGEZAL)
- op == 0x00 with funct == 0x09 (JALR)
- op == 0x03 (JAL)
REQ-021 Buffer structure and occupancy:
- Circular FIFO of DEPTH entries with read and write pointers wrapping modulo DEPTH.
- Occupancy counter of width clog2(DEPTH+1).
REQ-022 Ready and valid generation:
- in_ready_o = (count < DEPTH); it is combinational from the counter only, so there is no ready-from-ready path.
- out_valid_o = (count != 0).
REQ-023 Latency and throughput:
- An accepted instruction appears at the outputs with out_valid_o = 1 in the next cycle when the buffer was empty.
- Sustained throughput is 1 instruction/cycle while out_ready_i = 1.
REQ-024 Simultaneous push and pop with 0 < count < DEPTH: count is unchanged, both pointers advance, and order is preserved.
REQ-025 Full buffer (count == DEPTH): in_ready_o = 0, and no push occurs even if a pop happens in the same cycle; in_ready_o returns to 1 the cycle after the pop.
REQ-026 Empty buffer: out_valid_o = 0, and the head output fields hold their last values; consumers do not rely on them.
REQ-027 Outputs are stable while out_valid_o && !out_ready_i, including fields and pc_o.
REQ-028 flush_i = 1 behaviour:
- Next cycle: count = 0, pointers = 0, out_valid_o = 0.
- Any input offered in the flush cycle is dropped.
- flush_i has priority over push and pop.

Reset
REQ-029 While rst_n_i = 0 at a rising edge, the block clears state as follows:
- count, read pointer, write pointer: 0
- out_valid_o: 0
- in_ready_o: 1
- All head output fields: 0
REQ-030 Reset mid-operation discards every buffered entry; reset has priority over flush_i, push and pop.
REQ-031 Buffer storage contents are not reset; only the valid state and the head output register are.

Verification
REQ-032 Single JAL: instr 0x0C000010, pc 0x400, out_ready_i = 1 -> next cycle out_valid_o = 1 with:
- is_j_type_o = 1, use_link_reg_o = 1
- target_o = 0x0000010, op_o = 0x03, pc_o = 0x400
REQ-033 Immediate extension: ADDI 0x20218000:
- sign_ext_i = 1 -> imm_o = 0xFFFF8000
- sign_ext_i = 0 -> imm_o = 0x00008000
- In both cases is_i_type_o = 1 and use_link_reg_o = 0.
REQ-034 Link decode: JALR 0x00200009 -> is_r_type_o = 1, use_link_reg_o = 1; BGEZAL 0x04310004 -> use_link_reg_o = 1; BGEZ 0x04210004 -> use_link_reg_o = 0.
REQ-035 Backpressure (DEPTH = 2): out_ready_i = 0, offer 3 instructions on consecutive cycles -> first two accepted, then in_ready_o = 0; raise out_ready_i -> the three emerge in order, one per cycle after the third is accepted.
REQ-036 Flush with full buffer: 2 entries buffered, flush_i pulsed together with in_valid_i -> next cycle out_valid_o = 0, in_ready_o = 1, and the flushed input never appears.
REQ-037 Reset mid-stream: rst_n_i = 0 for one cycle while count = 1 and a push is offered -> after the edge, count = 0, out_valid_o = 0, and all outputs are 0.

Source files
------------

// File: rtl/decode_pipe.sv
// MIPS instruction decode stage: decodes on enqueue into a small circular buffer
// and presents the head entry from a dedicated output register.
module decode_pipe #(
    parameter int IMM_W = 32,
    parameter int PC_W  = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      instr_i,
    input  logic [PC_W-1:0]  pc_i,
    input  logic             sign_ext_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [4:0]       rs_o,
    output logic [4:0]       rt_o,
    output logic [4:0]       rd_o,
    output logic [4:0]       shamt_o,
    output logic [5:0]       op_o,
    output logic [5:0]       funct_o,
    output logic [25:0]      target_o,
    output logic [IMM_W-1:0] imm_o,
    output logic [PC_W-1:0]  pc_o,
    output logic             is_r_type_o,
    output logic             is_i_type_o,
    output logic             is_j_type_o,
    output logic             use_link_reg_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [5:0]       op;
        logic [4:0]       rs;
        logic [4:0]       rt;
        logic [4:0]       rd;
        logic [4:0]       shamt;
        logic [5:0]       funct;
        logic [25:0]      target;
        logic [IMM_W-1:0] imm;
        logic [PC_W-1:0]  pc;
        logic             is_r;
        logic             is_i;
        logic             is_j;
        logic             link;
    } entry_t;

    // Handshake: a transfer happens on a rising edge where valid && ready && !flush_i;
    // ready never depends on the opposite side's ready, only on occupancy.
    entry_t           mem [DEPTH];
    entry_t           dec;
    entry_t           head_q;
    entry_t           head_d;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_nxt;
    logic [PTR_W-1:0] wr_nxt;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

    assign in_ready_o  = (count < CNT_W'(DEPTH));
    assign out_valid_o = (count != '0);
    assign push        = in_valid_i && in_ready_o && !flush_i;
    assign pop         = out_valid_o && out_ready_i && !flush_i;
    assign rd_nxt      = (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
    assign wr_nxt      = (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;

    always_comb begin
        dec            = '0;
        dec.op         = instr_i[31:26];
        dec.rs         = instr_i[25:21];
        dec.rt         = instr_i[20:16];
        dec.rd         = instr_i[15:11];
        dec.shamt      = instr_i[10:6];
        dec.funct      = instr_i[5:0];
        dec.target     = instr_i[25:0];
        dec.imm        = {IMM_W{sign_ext_i & instr_i[15]}};
        dec.imm[15:0]  = instr_i[15:0];
        dec.pc         = pc_i;
        dec.is_r       = (dec.op == 6'h00);
        dec.is_j       = (dec.op == 6'h02) || (dec.op == 6'h03);
        dec.is_i       = !dec.is_r && !dec.is_j;
        dec.link       = ((dec.op == 6'h01) && ((dec.rt == 5'h10) || (dec.rt == 5'h11)))
                       || ((dec.op == 6'h00) && (dec.funct == 6'h09))
                       || (dec.op == 6'h03);
    end

    // The head register tracks mem[rd_ptr]; a push into an empty (or emptying)
    // buffer bypasses storage so the entry is visible one cycle later.
    always_comb begin
        head_d = head_q;
        if (pop) begin
            if (count == CNT_W'(1)) begin
                if (push) head_d = dec;
            end else begin
                head_d = mem[rd_nxt];
            end
        end else if (push && (count == '0)) begin
            head_d = dec;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_n_i && push) mem[wr_ptr] <= dec;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            head_q <= '0;
        end else if (flush_i) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_nxt;
            if (pop)  rd_ptr <= rd_nxt;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            head_q <= head_d;
        end
    end

    assign op_o           = head_q.op;
    assign rs_o           = head_q.rs;
    assign rt_o           = head_q.rt;
    assign rd_o           = head_q.rd;
    assign shamt_o        = head_q.shamt;
    assign funct_o        = head_q.funct;
    assign target_o       = head_q.target;
    assign imm_o          = head_q.imm;
    assign pc_o           = head_q.pc;
    assign is_r_type_o    = head_q.is_r;
    assign is_i_type_o    = head_q.is_i;
    assign is_j_type_o    = head_q.is_j;
    assign use_link_reg_o = head_q.link;

endmodule

// File: tb/tb_decode_pipe.sv
// Bench for decode_pipe: decode vector table, backpressure/flush/reset sequences,
// and a random stream checked through an expected-entry queue.
module tb_decode_pipe;

    localparam int DEPTH = 2;

    typedef struct packed {
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [25:0] target;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        is_r;
        logic        is_i;
        logic        is_j;
        logic        link;
    } exp_t;
    localparam int EXP_W = $bits(exp_t);

    typedef struct {
        logic [31:0] instr;
        logic        sign;
        logic [31:0] pc;
        logic [5:0]  op;
        logic [25:0] target;
        logic [31:0] imm;
        logic        is_r;
        logic        is_i;
        logic        is_j;
        logic        link;
    } vec_t;

    logic        clk_i = 0;
    logic        rst_n_i;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] instr_i;
    logic [31:0] pc_i;
    logic        sign_ext_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [4:0]  rs_o, rt_o, rd_o, shamt_o;
    logic [5:0]  op_o, funct_o;
    logic [25:0] target_o;
    logic [31:0] imm_o;
    logic [31:0] pc_o;
    logic        is_r_type_o, is_i_type_o, is_j_type_o, use_link_reg_o;

    logic [EXP_W-1:0] exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    logic mon_en = 0;
    logic took   = 0;
    vec_t vecs [10];

    decode_pipe #(.IMM_W(32), .PC_W(32), .DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .instr_i(instr_i), .pc_i(pc_i), .sign_ext_i(sign_ext_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .rs_o(rs_o), .rt_o(rt_o), .rd_o(rd_o), .shamt_o(shamt_o),
        .op_o(op_o), .funct_o(funct_o), .target_o(target_o),
        .imm_o(imm_o), .pc_o(pc_o),
        .is_r_type_o(is_r_type_o), .is_i_type_o(is_i_type_o),
        .is_j_type_o(is_j_type_o), .use_link_reg_o(use_link_reg_o)
    );

    // clock / reset
    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    function automatic logic [EXP_W-1:0] model(input logic [31:0] w, input logic s,
                                               input logic [31:0] pc);
        exp_t e;
        e.op     = w[31:26];
        e.rs     = w[25:21];
        e.rt     = w[20:16];
        e.rd     = w[15:11];
        e.shamt  = w[10:6];
        e.funct  = w[5:0];
        e.target = w[25:0];
        e.imm    = (s && w[15]) ? (32'hFFFF0000 | 32'(w[15:0])) : 32'(w[15:0]);
        e.pc     = pc;
        e.is_r   = (e.op == 6'd0);
        e.is_j   = (e.op == 6'd2) || (e.op == 6'd3);
        e.is_i   = (e.op != 6'd0) && (e.op != 6'd2) && (e.op != 6'd3);
        e.link   = (e.op == 6'd3) || (e.op == 6'd0 && e.funct == 6'd9)
                 || (e.op == 6'd1 && (e.rt == 5'd16 || e.rt == 5'd17));
        return e;
    endfunction

    function automatic logic [EXP_W-1:0] actual();
        return {op_o, rs_o, rt_o, rd_o, shamt_o, funct_o, target_o, imm_o, pc_o,
                is_r_type_o, is_i_type_o, is_j_type_o, use_link_reg_o};
    endfunction

    // scoreboard: predicts the transfer at the coming edge from the queue occupancy
    always @(negedge clk_i) begin
        if (mon_en) begin
            if (!rst_n_i) begin
                exp_q.delete();
                took = 0;
            end else begin
                int sz;
                sz = exp_q.size();
                check("in_ready", 64'(in_ready_o), 64'(sz < DEPTH));
                check("out_valid", 64'(out_valid_o), 64'(sz != 0));
                took = 0;
                if (flush_i) begin
                    exp_q.delete();
                end else begin
                    if (out_ready_i && sz != 0) begin
                        logic [EXP_W-1:0] e;
                        e = exp_q.pop_front();
                        n_cmp++;
                        if (actual() !== e) begin
                            n_fail++;
                            $display("FAIL head_entry got=%0h want=%0h", actual(), e);
                        end
                    end
                    if (in_valid_i && sz < DEPTH) begin
                        exp_q.push_back(model(instr_i, sign_ext_i, pc_i));
                        took = 1;
                    end
                end
            end
        end
    end

    task automatic drive(input logic [31:0] w, input logic s, input logic [31:0] pc);
        in_valid_i = 1; instr_i = w; sign_ext_i = s; pc_i = pc;
    endtask

    task automatic step();
        @(posedge clk_i); #1;
    endtask

    initial begin
        vecs[0] = '{32'h0C000010, 1'b1, 32'h400, 6'h03, 26'h0000010, 32'h00000010, 0, 0, 1, 1};
        vecs[1] = '{32'h20218000, 1'b1, 32'h404, 6'h08, 26'h0218000, 32'hFFFF8000, 0, 1, 0, 0};
        vecs[2] = '{32'h20218000, 1'b0, 32'h408, 6'h08, 26'h0218000, 32'h00008000, 0, 1, 0, 0};
        vecs[3] = '{32'h00200009, 1'b1, 32'h40C, 6'h00, 26'h0200009, 32'h00000009, 1, 0, 0, 1};
        vecs[4] = '{32'h04310004, 1'b1, 32'h410, 6'h01, 26'h0310004, 32'h00000004, 0, 1, 0, 1};
        vecs[5] = '{32'h04210004, 1'b1, 32'h414, 6'h01, 26'h0210004, 32'h00000004, 0, 1, 0, 0};
        vecs[6] = '{32'h04100008, 1'b0, 32'h418, 6'h01, 26'h0100008, 32'h00000008, 0, 1, 0, 1};
        vecs[7] = '{32'h08000020, 1'b1, 32'h41C, 6'h02, 26'h0000020, 32'h00000020, 0, 0, 1, 0};
        vecs[8] = '{32'h00221820, 1'b1, 32'h420, 6'h00, 26'h0221820, 32'h00001820, 1, 0, 0, 0};
        vecs[9] = '{32'h8C22FFFC, 1'b1, 32'h424, 6'h23, 26'h022FFFC, 32'hFFFFFFFC, 0, 1, 0, 0};

        rst_n_i = 0; flush_i = 0; in_valid_i = 0; instr_i = 0; pc_i = 0;
        sign_ext_i = 0; out_ready_i = 1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_out_valid", 64'(out_valid_o), 64'd0);
        check("rst_in_ready", 64'(in_ready_o), 64'd1);
        check("rst_fields_lo", 64'(actual()), 64'd0);
        check("rst_fields_hi", 64'(actual() >> 64), 64'd0);
        step();
        rst_n_i = 1; mon_en = 1;

        // decode table, one instruction at a time, checked one cycle after acceptance
        foreach (vecs[i]) begin
            drive(vecs[i].instr, vecs[i].sign, vecs[i].pc);
            step();
            in_valid_i = 0;
            @(negedge clk_i);
            check($sformatf("v%0d_valid", i), 64'(out_valid_o), 64'd1);
            check($sformatf("v%0d_op", i), 64'(op_o), 64'(vecs[i].op));
            check($sformatf("v%0d_target", i), 64'(target_o), 64'(vecs[i].target));
            check($sformatf("v%0d_imm", i), 64'(imm_o), 64'(vecs[i].imm));
            check($sformatf("v%0d_pc", i), 64'(pc_o), 64'(vecs[i].pc));
            check($sformatf("v%0d_flags", i),
                  64'({is_r_type_o, is_i_type_o, is_j_type_o, use_link_reg_o}),
                  64'({vecs[i].is_r, vecs[i].is_i, vecs[i].is_j, vecs[i].link}));
            step();
        end

        // backpressure: third offer stalls, then three drain in order
        out_ready_i = 0;
        drive(32'h00221820, 1, 32'h500); step();
        drive(32'h20210001, 1, 32'h504); step();
        drive(32'h0C000100, 1, 32'h508);
        @(negedge clk_i);
        check("bp_in_ready", 64'(in_ready_o), 64'd0);
        check("bp_hold_pc0", 64'(pc_o), 64'h500);
        step();
        @(negedge clk_i);
        check("bp_hold_pc1", 64'(pc_o), 64'h500);
        step();
        out_ready_i = 1;
        step();
        step();
        in_valid_i = 0;
        step();
        @(negedge clk_i);
        check("bp_drained", 64'(out_valid_o), 64'd0);

        // flush with a full buffer and a concurrent offer
        out_ready_i = 0;
        drive(32'h20220002, 1, 32'h600); step();
        drive(32'h20230003, 1, 32'h604); step();
        flush_i = 1;
        drive(32'h0C000200, 1, 32'h608); step();
        flush_i = 0; in_valid_i = 0; out_ready_i = 1;
        @(negedge clk_i);
        check("fl_out_valid", 64'(out_valid_o), 64'd0);
        check("fl_in_ready", 64'(in_ready_o), 64'd1);
        repeat (3) step();

        // reset with one entry buffered and a push offered
        out_ready_i = 0;
        drive(32'h8C22FFFC, 1, 32'h700); step();
        rst_n_i = 0;
        drive(32'h0C000300, 1, 32'h704); step();
        rst_n_i = 1; in_valid_i = 0;
        @(negedge clk_i);
        check("mr_out_valid", 64'(out_valid_o), 64'd0);
        check("mr_in_ready", 64'(in_ready_o), 64'd1);
        check("mr_fields_lo", 64'(actual()), 64'd0);
        check("mr_fields_hi", 64'(actual() >> 64), 64'd0);
        step();

        // sustained throughput: back-to-back stream with consumer always ready
        out_ready_i = 1;
        for (int k = 0; k < 8; k++) begin
            drive($urandom(), 1'($urandom_range(0, 1)), 32'h800 + 32'(4 * k));
            step();
            if (k > 0) begin
                @(negedge clk_i);
                check("tp_valid", 64'(out_valid_o), 64'd1);
            end
        end
        in_valid_i = 0;
        step();

        // random traffic; an offer is held until the scoreboard sees it accepted
        for (int k = 0; k < 300; k++) begin
            if (!in_valid_i || took) begin
                logic [31:0] w;
                w = $urandom();
                case ($urandom_range(0, 4))
                    0: w[31:26] = 6'h00;
                    1: w[31:26] = 6'h03;
                    2: begin w[31:26] = 6'h01; w[20:16] = 5'h10 | 5'($urandom_range(0, 1)); end
                    3: w[31:26] = 6'h02;
                    default: ;
                endcase
                in_valid_i = 1'($urandom_range(0, 1));
                instr_i = w; sign_ext_i = 1'($urandom_range(0, 1));
                pc_i = 32'h1000 + 32'(4 * k);
            end
            out_ready_i = 1'($urandom_range(0, 3) != 0);
            flush_i = ($urandom_range(0, 40) == 0);
            step();
        end
        in_valid_i = 0; flush_i = 0; out_ready_i = 1;
        repeat (DEPTH + 2) step();
        check("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
